// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI write arbiter: FSM encoding, watchdog width,
// grant-index width and ring-wrap arithmetic used by the round-robin picker.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    localparam int WDOG_W = 16;

    // A single requester still needs a 1-bit grant index.
    function automatic int grant_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int wrap_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/axi_write_arbiter_if.sv
// Requester-side and downstream AXI-like write signals of the arbiter, bundled.
// master = arbiter side (drives AW/W and acks), slave = environment side.
interface axi_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    import axi_arb_pkg::*;

    localparam int GRANT_W = grant_w(NUM_REQ);
    localparam int STRB_W  = DATA_WIDTH / 8;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ*STRB_W-1:0]     req_strb;
    logic [NUM_REQ-1:0]            req_ack;

    logic                          axi_awvalid;
    logic [ADDR_WIDTH-1:0]         axi_awaddr;
    logic                          axi_awready;
    logic                          axi_wvalid;
    logic [DATA_WIDTH-1:0]         axi_wdata;
    logic [STRB_W-1:0]             axi_wstrb;
    logic                          axi_wready;

    logic [GRANT_W-1:0]            grant_id;
    logic                          busy;
    logic                          timeout_err;

    modport master (
        input  req_valid, req_addr, req_data, req_strb, axi_awready, axi_wready,
        output req_ack, axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_wstrb,
        output grant_id, busy, timeout_err
    );

    modport slave (
        output req_valid, req_addr, req_data, req_strb, axi_awready, axi_wready,
        input  req_ack, axi_awvalid, axi_awaddr, axi_wvalid, axi_wdata, axi_wstrb,
        input  grant_id, busy, timeout_err
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last_grant+1 with wrap.
// Zero latency; no handshake, pure function of its inputs.
module rr_pick
    import axi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GW      = grant_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      last_grant,
    output logic               found,
    output logic [GW-1:0]      index
);

    always_comb begin
        found = 1'b0;
        index = '0;
        // Offsets 1..NUM_REQ visit every requester once, last_grant itself last.
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!found && req[GW'(wrap_idx(int'(last_grant), off, NUM_REQ))]) begin
                found = 1'b1;
                index = GW'(wrap_idx(int'(last_grant), off, NUM_REQ));
            end
        end
    end

endmodule

// File: rtl/axi_write_arbiter.sv
// Round-robin arbiter sharing one AW+W write port; payload captured at grant, one-cycle ack.
// Grant->valids 1 cycle, >=3 cycles per transfer; AW/W wait independently on their readys.
module axi_write_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk_domain_a,
    input  logic               rst_n,
    axi_write_arbiter_if.master bus
);

    localparam int GW     = grant_w(NUM_REQ);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0]     GRANT_RST = GW'(NUM_REQ - 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_W-1:0]     strb;
    } wr_t;

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [GW-1:0]     last_grant;
    logic [GW-1:0]     grant_q;
    wr_t               hold_q;
    wr_t               pick_wr;
    logic              aw_pend;
    logic              w_pend;
    logic              aw_done_now;
    logic              w_done_now;
    logic [WDOG_W-1:0] wdog_cnt;
    logic              timeout_q;
    logic              pick_found;
    logic [GW-1:0]     pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_pick (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .found      (pick_found),
        .index      (pick_idx)
    );

    always_comb begin
        pick_wr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == GW'(i)) begin
                pick_wr.addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                pick_wr.data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                pick_wr.strb = bus.req_strb[i*STRB_W +: STRB_W];
            end
        end
    end

    // A channel counts as finished if it already handshook or handshakes this cycle.
    assign aw_done_now = !aw_pend || bus.axi_awready;
    assign w_done_now  = !w_pend  || bus.axi_wready;

    always_ff @(posedge clk_domain_a or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bus.req_ack = '0;
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (aw_done_now && w_done_now) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.req_ack[grant_q] = 1'b1;
                state_nxt            = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_domain_a or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GRANT_RST;
            grant_q    <= '0;
            hold_q     <= '0;
            aw_pend    <= 1'b0;
            w_pend     <= 1'b0;
            wdog_cnt   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        hold_q   <= pick_wr;
                        grant_q  <= pick_idx;
                        aw_pend  <= 1'b1;
                        w_pend   <= 1'b1;
                        wdog_cnt <= '0;
                    end
                end
                ISSUE: begin
                    if (aw_pend && bus.axi_awready) begin
                        aw_pend <= 1'b0;
                    end
                    if (w_pend && bus.axi_wready) begin
                        w_pend <= 1'b0;
                    end
                    if (wdog_cnt != '1) begin
                        wdog_cnt <= wdog_cnt + 1'b1;
                    end
                    // Sticky: the counter reaching TIMEOUT_CYCLES on this edge raises the flag.
                    if (wdog_cnt >= WDOG_LAST) begin
                        timeout_q <= 1'b1;
                    end
                end
                DONE: begin
                    last_grant <= grant_q;
                end
                default: begin
                    aw_pend <= 1'b0;
                    w_pend  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.axi_awvalid = aw_pend;
    assign bus.axi_wvalid  = w_pend;
    assign bus.axi_awaddr  = hold_q.addr;
    assign bus.axi_wdata   = hold_q.data;
    assign bus.axi_wstrb   = hold_q.strb;
    assign bus.grant_id    = grant_q;
    assign bus.busy        = (state != IDLE);
    assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Self-checking bench for axi_write_arbiter: directed scenarios plus randomized transfers
// checked against a transaction-level round-robin / handshake / watchdog model.
module tb_axi_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic clk_domain_a = 1'b0;
    logic rst_n        = 1'b0;

    always #5 clk_domain_a = ~clk_domain_a;

    axi_write_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    axi_write_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_domain_a (clk_domain_a),
        .rst_n        (rst_n),
        .bus          (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: the winner is the first requester found walking the ring after the last winner.
    function automatic int rr_winner(input logic [N-1:0] rv, input int last);
        for (int off = 1; off <= N; off++) begin
            if (rv[(last + off) % N]) return (last + off) % N;
        end
        return -1;
    endfunction

    task automatic drive_idle();
        bus.req_valid   = '0;
        bus.req_addr    = '0;
        bus.req_data    = '0;
        bus.req_strb    = '0;
        bus.axi_awready = 1'b0;
        bus.axi_wready  = 1'b0;
    endtask

    task automatic randomize_lanes();
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*AW +: AW] = AW'($urandom);
            bus.req_data[i*DW +: DW] = $urandom;
            bus.req_strb[i*SW +: SW] = SW'($urandom);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk_domain_a);
        rst_n = 1'b1;
        @(negedge clk_domain_a);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        @(negedge clk_domain_a);
        total++; if ({bus.axi_awvalid, bus.axi_wvalid, bus.busy, bus.timeout_err} !== 4'b0) begin bad++; $display("FAIL reset_ctrl got=%b exp=0000", {bus.axi_awvalid, bus.axi_wvalid, bus.busy, bus.timeout_err}); end
        total++; if ({bus.axi_awaddr, bus.axi_wdata, bus.axi_wstrb} !== '0) begin bad++; $display("FAIL reset_payload got=%h exp=0", {bus.axi_awaddr, bus.axi_wdata, bus.axi_wstrb}); end
        total++; if ({bus.req_ack, bus.grant_id} !== '0) begin bad++; $display("FAIL reset_ack_gid got=%b exp=0", {bus.req_ack, bus.grant_id}); end
        rst_n = 1'b1;
        @(negedge clk_domain_a);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_single();
        randomize_lanes();
        bus.req_valid = 4'b0100;
        bus.req_addr[2*AW +: AW] = 16'h1234;
        bus.req_data[2*DW +: DW] = 32'hDEADBEEF;
        bus.req_strb[2*SW +: SW] = 4'hF;
        bus.axi_awready = 1'b1;
        bus.axi_wready  = 1'b1;
        @(negedge clk_domain_a);
        total++; if ({bus.axi_awvalid, bus.axi_wvalid} !== 2'b11) begin bad++; $display("FAIL single_valids got=%b exp=11", {bus.axi_awvalid, bus.axi_wvalid}); end
        total++; if (bus.axi_awaddr !== 16'h1234) begin bad++; $display("FAIL single_awaddr got=%h exp=1234", bus.axi_awaddr); end
        total++; if (bus.axi_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_wdata got=%h exp=deadbeef", bus.axi_wdata); end
        total++; if (bus.axi_wstrb !== 4'hF) begin bad++; $display("FAIL single_wstrb got=%h exp=f", bus.axi_wstrb); end
        total++; if (bus.grant_id !== 2'd2) begin bad++; $display("FAIL single_grant got=%0d exp=2", bus.grant_id); end
        bus.req_valid = '0;
        @(negedge clk_domain_a);
        total++; if (bus.req_ack !== 4'b0100) begin bad++; $display("FAIL single_ack got=%b exp=0100", bus.req_ack); end
        total++; if ({bus.axi_awvalid, bus.axi_wvalid} !== 2'b00) begin bad++; $display("FAIL single_valids_drop got=%b exp=00", {bus.axi_awvalid, bus.axi_wvalid}); end
        @(negedge clk_domain_a);
        total++; if ({bus.busy, bus.req_ack} !== 5'b0) begin bad++; $display("FAIL single_idle got=%b exp=00000", {bus.busy, bus.req_ack}); end
        total++; if (bus.grant_id !== 2'd2) begin bad++; $display("FAIL single_grant_hold got=%0d exp=2", bus.grant_id); end
    endtask

    task automatic test_round_robin();
        int n_ack;
        apply_reset();
        randomize_lanes();
        bus.req_valid   = 4'b1111;
        bus.axi_awready = 1'b1;
        bus.axi_wready  = 1'b1;
        n_ack = 0;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            @(negedge clk_domain_a);
            if (bus.req_ack != '0) begin
                total++;
                if (cyc !== 2 + 3*n_ack || bus.req_ack !== 4'(1 << (n_ack % N))) begin
                    bad++; $display("FAIL rr_ack%0d got=%b@%0d exp=%b@%0d", n_ack, bus.req_ack, cyc, 4'(1 << (n_ack % N)), 2 + 3*n_ack);
                end
                n_ack++;
                if (n_ack == 5) bus.req_valid = '0;
            end
        end
        total++; if (n_ack !== 5) begin bad++; $display("FAIL rr_ack_count got=%0d exp=5", n_ack); end
    endtask

    task automatic test_split();
        bus.req_valid   = 4'b0010;
        bus.axi_awready = 1'b1;
        bus.axi_wready  = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_domain_a);
            bus.req_valid = '0;
            total++; if ({bus.axi_awvalid, bus.axi_wvalid, bus.req_ack} !== {(k == 1), 1'b1, 4'b0}) begin bad++; $display("FAIL split_c%0d got=%b exp=%b", k, {bus.axi_awvalid, bus.axi_wvalid, bus.req_ack}, {(k == 1), 1'b1, 4'b0}); end
            bus.axi_wready = (k == 6);
        end
        @(negedge clk_domain_a);
        total++; if ({bus.axi_wvalid, bus.req_ack} !== 5'b0_0010) begin bad++; $display("FAIL split_ack got=%b exp=00010", {bus.axi_wvalid, bus.req_ack}); end
        @(negedge clk_domain_a);
        total++; if ({bus.busy, bus.req_ack} !== 5'b0) begin bad++; $display("FAIL split_idle got=%b exp=00000", {bus.busy, bus.req_ack}); end
    endtask

    task automatic test_watchdog();
        apply_reset();
        bus.req_valid = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_domain_a);
            total++; if ({bus.timeout_err, bus.axi_awvalid, bus.axi_wvalid, bus.req_ack} !== {(k >= TO + 1), 2'b11, 4'b0}) begin bad++; $display("FAIL wdog_c%0d got=%b exp=%b", k, {bus.timeout_err, bus.axi_awvalid, bus.axi_wvalid, bus.req_ack}, {(k >= TO + 1), 2'b11, 4'b0}); end
            if (k == 12) begin
                bus.axi_awready = 1'b1;
                bus.axi_wready  = 1'b1;
                bus.req_valid   = '0;
            end
        end
        @(negedge clk_domain_a);
        total++; if ({bus.req_ack, bus.timeout_err} !== 5'b0001_1) begin bad++; $display("FAIL wdog_ack got=%b exp=00011", {bus.req_ack, bus.timeout_err}); end
        repeat (3) @(negedge clk_domain_a);
        total++; if ({bus.busy, bus.timeout_err} !== 2'b01) begin bad++; $display("FAIL wdog_sticky got=%b exp=01", {bus.busy, bus.timeout_err}); end
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] a0;
        bus.axi_awready = 1'b0;
        bus.axi_wready  = 1'b0;
        bus.req_valid   = 4'b0100;
        @(negedge clk_domain_a);
        @(negedge clk_domain_a);
        total++; if (bus.axi_awvalid !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b exp=1", bus.axi_awvalid); end
        #1 rst_n = 1'b0;
        #1;
        total++; if ({bus.axi_awvalid, bus.axi_wvalid, bus.busy, bus.timeout_err} !== 4'b0) begin bad++; $display("FAIL rstmid_async got=%b exp=0000", {bus.axi_awvalid, bus.axi_wvalid, bus.busy, bus.timeout_err}); end
        bus.axi_awready = 1'b1;
        bus.axi_wready  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_domain_a);
            total++; if (bus.req_ack !== 4'b0) begin bad++; $display("FAIL rstmid_noack%0d got=%b exp=0000", k, bus.req_ack); end
        end
        randomize_lanes();
        a0 = bus.req_addr[0 +: AW];
        bus.req_valid = 4'b1111;
        rst_n = 1'b1;
        @(negedge clk_domain_a);
        total++; if ({bus.grant_id, bus.axi_awvalid} !== {2'd0, 1'b1}) begin bad++; $display("FAIL rstmid_first got=%b exp=001", {bus.grant_id, bus.axi_awvalid}); end
        total++; if (bus.axi_awaddr !== a0) begin bad++; $display("FAIL rstmid_addr got=%h exp=%h", bus.axi_awaddr, a0); end
        @(negedge clk_domain_a);
        bus.req_valid = '0;
        total++; if (bus.req_ack !== 4'b0001) begin bad++; $display("FAIL rstmid_ack got=%b exp=0001", bus.req_ack); end
        @(negedge clk_domain_a);
    endtask

    task automatic test_random();
        int last, w, daw, dw, len;
        logic err_m;
        logic [N-1:0] rv;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [SW-1:0] es;
        logic aw_d, w_d;
        apply_reset();
        last  = N - 1;
        err_m = 1'b0;
        for (int t = 0; t < 150; t++) begin
            rv = 4'($urandom_range(1, 15));
            randomize_lanes();
            w  = rr_winner(rv, last);
            ea = bus.req_addr[w*AW +: AW];
            ed = bus.req_data[w*DW +: DW];
            es = bus.req_strb[w*SW +: SW];
            daw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 3));
            dw  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 3));
            bus.req_valid   = rv;
            bus.axi_awready = 1'b0;
            bus.axi_wready  = 1'b0;
            aw_d = 1'b0; w_d = 1'b0; len = 0;
            for (int k = 1; k <= 20 && len == 0; k++) begin
                @(negedge clk_domain_a);
                total++; if ({bus.axi_awvalid, bus.axi_wvalid, bus.busy, bus.req_ack, bus.timeout_err} !== {!aw_d, !w_d, 1'b1, 4'b0, (err_m || k >= TO + 1)}) begin bad++; $display("FAIL rnd%0d_ctrl_c%0d got=%b exp=%b", t, k, {bus.axi_awvalid, bus.axi_wvalid, bus.busy, bus.req_ack, bus.timeout_err}, {!aw_d, !w_d, 1'b1, 4'b0, (err_m || k >= TO + 1)}); end
                total++; if ({bus.grant_id, bus.axi_awaddr, bus.axi_wdata, bus.axi_wstrb} !== {2'(w), ea, ed, es}) begin bad++; $display("FAIL rnd%0d_payload_c%0d got=%h exp=%h", t, k, {bus.grant_id, bus.axi_awaddr, bus.axi_wdata, bus.axi_wstrb}, {2'(w), ea, ed, es}); end
                bus.req_valid   = 4'($urandom);
                randomize_lanes();
                bus.axi_awready = (k > daw);
                bus.axi_wready  = (k > dw);
                if (k > daw) aw_d = 1'b1;
                if (k > dw)  w_d  = 1'b1;
                if (aw_d && w_d) len = k;
            end
            @(negedge clk_domain_a);
            total++; if ({bus.req_ack, bus.timeout_err} !== {4'(1 << w), (err_m || len >= TO)}) begin bad++; $display("FAIL rnd%0d_ack got=%b exp=%b", t, {bus.req_ack, bus.timeout_err}, {4'(1 << w), (err_m || len >= TO)}); end
            bus.req_valid = '0;
            err_m = err_m || (len >= TO);
            last  = w;
            @(negedge clk_domain_a);
            total++; if ({bus.busy, bus.req_ack, bus.grant_id} !== {1'b0, 4'b0, 2'(w)}) begin bad++; $display("FAIL rnd%0d_idle got=%b exp=%b", t, {bus.busy, bus.req_ack, bus.grant_id}, {1'b0, 4'b0, 2'(w)}); end
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_single();
        test_round_robin();
        test_split();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
